// File: rtl/clk_div_multi_if.sv
// Divisor/mode write bus for clk_div_multi.
// Master drives the write strobe; the divider consumes it.
interface clk_div_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_div;
    logic             wr_mode;

    modport master (
        output wr_en, wr_ch, wr_div, wr_mode
    );

    modport slave (
        input wr_en, wr_ch, wr_div, wr_mode
    );
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable toggle/pulse divider.
// Define CLK_DIV_PHASE_SYNC_EN to add a phase-aligning sync input.
module clk_div_multi #(
    parameter int          CHANNELS    = 4,
    parameter int          WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CLK_DIV_PHASE_SYNC_EN
    input  logic                sync,
`endif
    input  logic [CHANNELS-1:0] en,
    clk_div_multi_if.slave      wr,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pend
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]    cnt   [CHANNELS];
    logic [WIDTH-1:0]    div_a [CHANNELS];
    logic [WIDTH-1:0]    div_s [CHANNELS];
    logic [CHANNELS-1:0] mode_a;
    logic [CHANNELS-1:0] mode_s;
    logic [CHANNELS-1:0] term;
    logic [CHANNELS-1:0] hit;

    // >= rather than == so a stale count above a shrunk divisor still ends
    always_comb begin
        term = '0;
        hit  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            term[i] = en[i] && (div_a[i] != '0)
                      && (cnt[i] >= div_a[i] - WIDTH'(1));
            hit[i]  = wr.wr_en && (wr.wr_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]    <= '0;
                div_a[i]  <= DEF_DIV;
                div_s[i]  <= DEF_DIV;
                mode_a[i] <= 1'b0;
                mode_s[i] <= 1'b0;
                out[i]    <= 1'b0;
                tick[i]   <= 1'b0;
                pend[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
`ifdef CLK_DIV_PHASE_SYNC_EN
                if (sync) begin
                    cnt[i]  <= '0;
                    out[i]  <= 1'b0;
                    tick[i] <= 1'b0;
                    if (pend[i]) begin
                        div_a[i]  <= div_s[i];
                        mode_a[i] <= mode_s[i];
                    end
                    pend[i] <= 1'b0;
                end else
`endif
                if (div_a[i] == '0) begin
                    cnt[i]  <= '0;
                    out[i]  <= 1'b0;
                    tick[i] <= 1'b0;
                    if (pend[i]) begin
                        div_a[i]  <= div_s[i];
                        mode_a[i] <= mode_s[i];
                    end
                    pend[i] <= 1'b0;
                end else if (term[i]) begin
                    cnt[i]    <= '0;
                    tick[i]   <= 1'b1;
                    div_a[i]  <= div_s[i];
                    mode_a[i] <= mode_s[i];
                    pend[i]   <= 1'b0;
                    out[i]    <= mode_s[i] ? 1'b1 : ~out[i];
                end else begin
                    if (en[i])
                        cnt[i] <= cnt[i] + WIDTH'(1);
                    tick[i] <= 1'b0;
                    if (mode_a[i])
                        out[i] <= 1'b0;
                end
                // a write lands after any commit, so it keeps pend set
                if (hit[i]) begin
                    div_s[i]  <= wr.wr_div;
                    mode_s[i] <= wr.wr_mode;
                    pend[i]   <= 1'b1;
                end
            end
        end
    end
endmodule
